pcmd3180_seq: RTL

Power and stream sequencer for the PCMD3180 TDM capture path. Drives the codec's SHDNZ pin, holds the TDM receive master in reset until the codec is powered, discards the first frames while the codec settles, and forwards frame-complete strobes only while the stream is good. Enable requests from the host are level-based. Shutdown is orderly: clocks keep running through a drain period before SHDNZ falls.

---
 rtl/pcmd3180_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pcmd3180_seq.sv
// Power/stream sequencer for the PCMD3180 TDM capture path: SHDNZ, TDM master reset, settle and drain.
// Optional frame watchdog is compiled in with `define PCMD_SEQ_WATCHDOG_EN.
module pcmd3180_seq #(
    parameter int ShdnzDelay   = 8,
    parameter int SettleFrames = 2,
    parameter int StopFrames   = 1,
    parameter int WdogCycles   = 64
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic enable_i,
    input  logic rx_valid_i,
    output logic pcmd_shdnz_o,
    output logic tdm_rstn_o,
    output logic frame_valid_o,
    output logic running_o,
    output logic busy_o,
    output logic fault_o
);

    localparam int MaxAb  = (ShdnzDelay > SettleFrames) ? ShdnzDelay : SettleFrames;
    localparam int MaxCd  = (StopFrames > WdogCycles) ? StopFrames : WdogCycles;
    localparam int MaxAll = (MaxAb > MaxCd) ? MaxAb : MaxCd;
    localparam int CntW   = $clog2(MaxAll) + 1;

    localparam logic [CntW-1:0] DelayLast  = CntW'(ShdnzDelay - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'((SettleFrames > 0) ? SettleFrames - 1 : 0);
    localparam logic [CntW-1:0] StopLast   = CntW'(StopFrames - 1);

    typedef enum logic [2:0] {
        ST_OFF, ST_POWERUP, ST_SETTLE, ST_RUN, ST_DRAIN, ST_POWERDOWN
    } state_t;

    state_t          state_reg, state_next;
    logic [CntW-1:0] cnt_reg, cnt_next;
    logic            rx_prev_reg, edge_reg;
    logic            shdnz_reg, shdnz_next;
    logic            tdm_rstn_reg, tdm_rstn_next;
    logic            frame_valid_reg, frame_valid_next;
    logic            running_reg, running_next;
    logic            busy_reg, busy_next;
    logic            wdog_trip;

`ifdef PCMD_SEQ_WATCHDOG_EN
    localparam logic [CntW-1:0] WdogLast = CntW'(WdogCycles - 1);
    logic [CntW-1:0] wdog_cnt_reg;
    logic            fault_reg, fault_next;
    logic            wdog_active;

    assign wdog_active = (state_reg == ST_SETTLE) || (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign wdog_trip   = wdog_active && !edge_reg && (wdog_cnt_reg == WdogLast);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wdog_cnt_reg <= '0;
            fault_reg    <= 1'b0;
        end else begin
            wdog_cnt_reg <= (wdog_active && !edge_reg) ? wdog_cnt_reg + 1'b1 : '0;
            fault_reg    <= fault_next;
        end
    end

    always_comb begin
        fault_next = fault_reg;
        if (wdog_trip)
            fault_next = 1'b1;
        else if (state_reg == ST_OFF && !enable_i)
            fault_next = 1'b0;
    end

    assign fault_o = fault_reg;
`else
    assign wdog_trip = 1'b0;
    assign fault_o   = 1'b0;
`endif

    // Frame = registered rising edge of rx_valid_i; held clear while the TDM master is in reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_prev_reg <= 1'b0;
            edge_reg    <= 1'b0;
        end else begin
            rx_prev_reg <= rx_valid_i;
            edge_reg    <= tdm_rstn_reg && rx_valid_i && !rx_prev_reg;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg       <= ST_OFF;
            cnt_reg         <= '0;
            shdnz_reg       <= 1'b0;
            tdm_rstn_reg    <= 1'b0;
            frame_valid_reg <= 1'b0;
            running_reg     <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            shdnz_reg       <= shdnz_next;
            tdm_rstn_reg    <= tdm_rstn_next;
            frame_valid_reg <= frame_valid_next;
            running_reg     <= running_next;
            busy_reg        <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_OFF: begin
                if (enable_i && !fault_o) state_next = ST_POWERUP;
            end
            ST_POWERUP: begin
                if (!enable_i)
                    state_next = ST_POWERDOWN;
                else if (cnt_reg == DelayLast)
                    state_next = (SettleFrames == 0) ? ST_RUN : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!enable_i)
                    state_next = ST_DRAIN;
                else if (edge_reg && cnt_reg == SettleLast)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!enable_i) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (edge_reg && cnt_reg == StopLast) state_next = ST_POWERDOWN;
            end
            ST_POWERDOWN: begin
                if (cnt_reg == DelayLast) state_next = ST_OFF;
            end
            default: state_next = ST_OFF;
        endcase
        if (wdog_trip) state_next = ST_POWERDOWN;
    end

    // SHDNZ and TDM reset follow directly from the state being entered, so every exit path drops them together.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg)
            cnt_next = '0;
        else if (state_reg == ST_POWERUP || state_reg == ST_POWERDOWN)
            cnt_next = cnt_reg + 1'b1;
        else if ((state_reg == ST_SETTLE || state_reg == ST_DRAIN) && edge_reg)
            cnt_next = cnt_reg + 1'b1;

        shdnz_next       = (state_next == ST_POWERUP) || (state_next == ST_SETTLE) ||
                           (state_next == ST_RUN)     || (state_next == ST_DRAIN);
        tdm_rstn_next    = (state_next == ST_SETTLE) || (state_next == ST_RUN) || (state_next == ST_DRAIN);
        frame_valid_next = (state_reg == ST_RUN) && edge_reg;
        running_next     = (state_next == ST_RUN);
        busy_next        = (state_next != ST_OFF) && (state_next != ST_RUN);
    end

    assign pcmd_shdnz_o  = shdnz_reg;
    assign tdm_rstn_o    = tdm_rstn_reg;
    assign frame_valid_o = frame_valid_reg;
    assign running_o     = running_reg;
    assign busy_o        = busy_reg;

endmodule
